// File: rtl/pong_defs.sv
// Shared pong geometry, timing constants and the ball state encoding.
// Also consumed by the graphics stage and the paddle drawing logic.
package pong_defs;

    // Screen and object geometry in pixels
    localparam int SCREEN_W     = 640;
    localparam int SCREEN_H     = 480;
    localparam int BALL_SIZE    = 8;
    localparam int SPEED_X      = 2;
    localparam int SPEED_Y      = 1;
    localparam int PADDLE_X     = 16;
    localparam int PADDLE_W     = 8;
    localparam int PADDLE_H     = 64;
    localparam int SERVE_FRAMES = 60;

    // 11-bit versions so the motion arithmetic has headroom and never wraps
    localparam logic [10:0] X_MAX_W       = 11'(SCREEN_W - BALL_SIZE);
    localparam logic [10:0] Y_MAX_W       = 11'(SCREEN_H - BALL_SIZE);
    localparam logic [10:0] SPEED_X_W     = 11'(SPEED_X);
    localparam logic [10:0] SPEED_Y_W     = 11'(SPEED_Y);
    localparam logic [10:0] PADDLE_EDGE_W = 11'(PADDLE_X + PADDLE_W);
    localparam logic [10:0] BALL_SIZE_W   = 11'(BALL_SIZE);
    localparam logic [10:0] PADDLE_H_W    = 11'(PADDLE_H);

    // 10-bit screen positions used for clamping and recentring
    localparam logic [9:0] X_MAX_POS     = 10'(SCREEN_W - BALL_SIZE);
    localparam logic [9:0] Y_MAX_POS     = 10'(SCREEN_H - BALL_SIZE);
    localparam logic [9:0] PADDLE_EDGE_X = 10'(PADDLE_X + PADDLE_W);
    localparam logic [9:0] CENTER_X      = 10'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [9:0] CENTER_Y      = 10'((SCREEN_H - BALL_SIZE) / 2);

    // Last serve-counter value before play starts
    localparam logic [5:0] SERVE_LAST = 6'(SERVE_FRAMES - 1);

    // Ball state machine encoding; 2'd3 is illegal and recovers to SERVE
    typedef enum logic [1:0] {
        ST_SERVE = 2'd0,
        ST_PLAY  = 2'd1,
        ST_MISS  = 2'd2
    } ball_state_e;

    // Saturating 4-bit increment for the miss counter
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        logic [3:0] r;
        if (v == 4'hF) begin
            r = v;
        end else begin
            r = v + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// Brings the graphics-stage end-of-frame level into the clk50M domain and
// turns each rising edge into a single-cycle tick.
module frame_tick_sync (
    input  logic clk50M,
    input  logic reset,
    input  logic endofframe,
    output logic tick
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // Two-flop synchroniser followed by a delay flop for edge detection
    always_ff @(posedge clk50M or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= endofframe;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Decoded purely from flops, so the tick is glitch-free
    assign tick = sync2_q & ~prev_q;

endmodule

// File: rtl/ball_physics.sv
// Ball game logic: advances the ball once per frame, bounces it off the
// walls and paddle one, detects misses and runs the serve/play/miss FSM.
module ball_physics
    import pong_defs::*;
(
    input  logic       clk50M,
    input  logic       reset,
    input  logic       endofframe,
    input  logic [9:0] paddle_one_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       ball_dir_right,
    output logic       ball_dir_down,
    output logic       serving,
    output logic [3:0] miss_count
);

    logic        tick_s;
    ball_state_e state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic        right_q, right_d;
    logic        down_q, down_d;
    logic        serving_q, serving_d;
    logic [3:0]  miss_q, miss_d;

    logic [10:0] x_ext_s, y_ext_s, py_ext_s;
    logic [10:0] x_plus_s, x_minus_s, y_plus_s, y_minus_s;
    logic        paddle_hit_s;

    frame_tick_sync u_tick (
        .clk50M     (clk50M),
        .reset      (reset),
        .endofframe (endofframe),
        .tick       (tick_s)
    );

    // Widened operands; the minus results are only used when they cannot underflow
    assign x_ext_s   = {1'b0, x_q};
    assign y_ext_s   = {1'b0, y_q};
    assign py_ext_s  = {1'b0, paddle_one_y};
    assign x_plus_s  = x_ext_s + SPEED_X_W;
    assign x_minus_s = x_ext_s - SPEED_X_W;
    assign y_plus_s  = y_ext_s + SPEED_Y_W;
    assign y_minus_s = y_ext_s - SPEED_Y_W;

    // Ball moving left would reach the paddle face this frame and overlaps it vertically
    assign paddle_hit_s = !right_q
                       && (x_ext_s >= PADDLE_EDGE_W)
                       && (x_minus_s <= PADDLE_EDGE_W)
                       && ((y_ext_s + BALL_SIZE_W) > py_ext_s)
                       && (y_ext_s < (py_ext_s + PADDLE_H_W));

    // Next-state logic: state only advances on a frame tick, except illegal-state recovery
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        x_d       = x_q;
        y_d       = y_q;
        right_d   = right_q;
        down_d    = down_q;
        miss_d    = miss_q;
        serving_d = 1'b0;

        case (state_q)
            ST_SERVE: begin
                if (tick_s) begin
                    if (cnt_q == SERVE_LAST) begin
                        state_d = ST_PLAY;
                        cnt_d   = 6'd0;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_PLAY: begin
                if (tick_s) begin
                    // Vertical axis
                    if (down_q) begin
                        if (y_plus_s >= Y_MAX_W) begin
                            y_d    = Y_MAX_POS;
                            down_d = 1'b0;
                        end else begin
                            y_d = 10'(y_plus_s);
                        end
                    end else begin
                        if (y_ext_s <= SPEED_Y_W) begin
                            y_d    = 10'd0;
                            down_d = 1'b1;
                        end else begin
                            y_d = 10'(y_minus_s);
                        end
                    end
                    // Horizontal axis, evaluated independently of the vertical one
                    if (right_q) begin
                        if (x_plus_s >= X_MAX_W) begin
                            x_d     = X_MAX_POS;
                            right_d = 1'b0;
                        end else begin
                            x_d = 10'(x_plus_s);
                        end
                    end else if (paddle_hit_s) begin
                        x_d     = PADDLE_EDGE_X;
                        right_d = 1'b1;
                    end else if (x_ext_s <= SPEED_X_W) begin
                        x_d     = 10'd0;
                        state_d = ST_MISS;
                    end else begin
                        x_d = 10'(x_minus_s);
                    end
                end else begin
                    state_d = ST_PLAY;
                end
            end
            ST_MISS: begin
                if (tick_s) begin
                    miss_d  = sat_inc4(miss_q);
                    x_d     = CENTER_X;
                    y_d     = CENTER_Y;
                    right_d = 1'b1;
                    cnt_d   = 6'd0;
                    state_d = ST_SERVE;
                end else begin
                    state_d = ST_MISS;
                end
            end
            default: begin
                state_d = ST_SERVE;
                cnt_d   = 6'd0;
            end
        endcase

        serving_d = (state_d == ST_SERVE);
    end

    // State and output registers; reset recentres the ball and waits to serve
    always_ff @(posedge clk50M or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_SERVE;
            cnt_q     <= 6'd0;
            x_q       <= CENTER_X;
            y_q       <= CENTER_Y;
            right_q   <= 1'b1;
            down_q    <= 1'b1;
            serving_q <= 1'b1;
            miss_q    <= 4'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            right_q   <= right_d;
            down_q    <= down_d;
            serving_q <= serving_d;
            miss_q    <= miss_d;
        end
    end

    assign ball_x         = x_q;
    assign ball_y         = y_q;
    assign ball_dir_right = right_q;
    assign ball_dir_down  = down_q;
    assign serving        = serving_q;
    assign miss_count     = miss_q;

endmodule

// File: tb/tb_ball_physics.sv
// Self-checking bench for ball_physics: a reference model pushes the expected
// outputs for every frame tick into a queue, which is popped and compared
// once the DUT has applied that tick.
module tb_ball_physics;

    logic       clk50M = 1'b0;
    logic       reset;
    logic       endofframe;
    logic [9:0] paddle_one_y;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic       ball_dir_right;
    logic       ball_dir_down;
    logic       serving;
    logic [3:0] miss_count;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       r;
        logic       d;
        logic       s;
        logic [3:0] m;
    } obs_t;

    obs_t exp_q[$];

    // Reference model state (0 = serve, 1 = play, 2 = miss)
    int m_x, m_y, m_r, m_d, m_st, m_cnt, m_miss;

    ball_physics dut (
        .clk50M         (clk50M),
        .reset          (reset),
        .endofframe     (endofframe),
        .paddle_one_y   (paddle_one_y),
        .ball_x         (ball_x),
        .ball_y         (ball_y),
        .ball_dir_right (ball_dir_right),
        .ball_dir_down  (ball_dir_down),
        .serving        (serving),
        .miss_count     (miss_count)
    );

    always #5 clk50M = ~clk50M;

    function automatic void model_reset();
        m_x = 316; m_y = 236; m_r = 1; m_d = 1; m_st = 0; m_cnt = 0; m_miss = 0;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.x = 10'(m_x);
        o.y = 10'(m_y);
        o.r = (m_r != 0);
        o.d = (m_d != 0);
        o.s = (m_st == 0);
        o.m = 4'(m_miss);
        return o;
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.x = ball_x;
        o.y = ball_y;
        o.r = ball_dir_right;
        o.d = ball_dir_down;
        o.s = serving;
        o.m = miss_count;
        return o;
    endfunction

    // One frame of game behaviour, written directly from the rules of play
    function automatic void model_step(input logic [9:0] py_l);
        int p, nx, ny, nr, nd, nst;
        p = int'(py_l);
        if (m_st == 0) begin
            if (m_cnt == 59) begin
                m_st = 1; m_cnt = 0;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end else if (m_st == 1) begin
            nx = m_x; ny = m_y; nr = m_r; nd = m_d; nst = 1;
            if (m_d == 1) begin
                if (m_y + 1 >= 472) begin ny = 472; nd = 0; end
                else ny = m_y + 1;
            end else begin
                if (m_y <= 1) begin ny = 0; nd = 1; end
                else ny = m_y - 1;
            end
            if (m_r == 1) begin
                if (m_x + 2 >= 632) begin nx = 632; nr = 0; end
                else nx = m_x + 2;
            end else if (m_x >= 24 && m_x - 2 <= 24 && m_y + 8 > p && m_y < p + 64) begin
                nx = 24; nr = 1;
            end else if (m_x <= 2) begin
                nx = 0; nst = 2;
            end else begin
                nx = m_x - 2;
            end
            m_x = nx; m_y = ny; m_r = nr; m_d = nd; m_st = nst;
        end else begin
            m_miss = (m_miss < 15) ? m_miss + 1 : 15;
            m_x = 316; m_y = 236; m_r = 1; m_cnt = 0; m_st = 0;
        end
    endfunction

    // Drive one short end-of-frame pulse and score the frame it produces
    task automatic do_tick(input logic [9:0] py_l, input string tag);
        obs_t prev, got, expv;
        prev = model_obs();
        model_step(py_l);
        exp_q.push_back(model_obs());
        paddle_one_y = py_l;
        endofframe   = 1'b1;
        @(posedge clk50M); @(negedge clk50M);
        endofframe = 1'b0;
        @(posedge clk50M); @(negedge clk50M);
        got = dut_obs();
        checks++;
        if (got !== prev) begin
            errors++;
            $display("FAIL %s_early: got x=%0d y=%0d r=%0b d=%0b s=%0b m=%0d, expected x=%0d y=%0d r=%0b d=%0b s=%0b m=%0d",
                     tag, got.x, got.y, got.r, got.d, got.s, got.m,
                     prev.x, prev.y, prev.r, prev.d, prev.s, prev.m);
        end
        @(posedge clk50M); @(negedge clk50M);
        expv = exp_q.pop_front();
        got  = dut_obs();
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got x=%0d y=%0d r=%0b d=%0b s=%0b m=%0d, expected x=%0d y=%0d r=%0b d=%0b s=%0b m=%0d",
                     tag, got.x, got.y, got.r, got.d, got.s, got.m,
                     expv.x, expv.y, expv.r, expv.d, expv.s, expv.m);
        end
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        endofframe   = 1'b0;
        paddle_one_y = 10'd0;
        model_reset();
        repeat (3) @(posedge clk50M);
        @(negedge clk50M);
        checks++; if (ball_x !== 10'd316) begin errors++; $display("FAIL reset_x: got %0d expected 316", ball_x); end
        checks++; if (ball_y !== 10'd236) begin errors++; $display("FAIL reset_y: got %0d expected 236", ball_y); end
        checks++; if (ball_dir_right !== 1'b1) begin errors++; $display("FAIL reset_right: got %0b expected 1", ball_dir_right); end
        checks++; if (ball_dir_down !== 1'b1) begin errors++; $display("FAIL reset_down: got %0b expected 1", ball_dir_down); end
        checks++; if (serving !== 1'b1) begin errors++; $display("FAIL reset_serving: got %0b expected 1", serving); end
        checks++; if (miss_count !== 4'd0) begin errors++; $display("FAIL reset_miss: got %0d expected 0", miss_count); end
        reset = 1'b1;
        repeat (2) @(negedge clk50M);
    endtask

    task automatic test_hold_high();
        obs_t got, expv;
        model_step(10'd400);
        exp_q.push_back(model_obs());
        paddle_one_y = 10'd400;
        endofframe   = 1'b1;
        repeat (3) @(posedge clk50M);
        @(negedge clk50M);
        expv = exp_q.pop_front();
        got  = dut_obs();
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL hold_first: got x=%0d y=%0d s=%0b, expected x=%0d y=%0d s=%0b",
                     got.x, got.y, got.s, expv.x, expv.y, expv.s);
        end
        repeat (997) @(posedge clk50M);
        @(negedge clk50M);
        checks++;
        if (ball_x !== 10'd316 || ball_y !== 10'd236 || serving !== 1'b1) begin
            errors++;
            $display("FAIL hold_single: got x=%0d y=%0d s=%0b, expected x=316 y=236 s=1",
                     ball_x, ball_y, serving);
        end
        endofframe = 1'b0;
        repeat (3) @(posedge clk50M);
        @(negedge clk50M);
    endtask

    // The hold test already gave one serve tick; 59 more end the serve
    task automatic test_serve();
        for (int i = 0; i < 59; i++) do_tick(10'd400, "serve");
        checks++;
        if (serving !== 1'b0 || ball_x !== 10'd316 || ball_y !== 10'd236) begin
            errors++;
            $display("FAIL serve_end: got s=%0b x=%0d y=%0d, expected s=0 x=316 y=236", serving, ball_x, ball_y);
        end
        do_tick(10'd400, "play1");
        checks++;
        if (ball_x !== 10'd318 || ball_y !== 10'd237) begin
            errors++;
            $display("FAIL play_first_move: got x=%0d y=%0d, expected x=318 y=237", ball_x, ball_y);
        end
    endtask

    task automatic test_walls();
        for (int p = 2; p <= 158; p++) do_tick(10'd400, "walls");
        checks++;
        if (ball_x !== 10'd632 || ball_dir_right !== 1'b0 || ball_y !== 10'd394) begin
            errors++;
            $display("FAIL right_wall: got x=%0d r=%0b y=%0d, expected x=632 r=0 y=394", ball_x, ball_dir_right, ball_y);
        end
        for (int p = 159; p <= 236; p++) do_tick(10'd400, "walls");
        checks++;
        if (ball_y !== 10'd472 || ball_dir_down !== 1'b0 || ball_x !== 10'd476) begin
            errors++;
            $display("FAIL bottom_wall: got y=%0d d=%0b x=%0d, expected y=472 d=0 x=476", ball_y, ball_dir_down, ball_x);
        end
    endtask

    task automatic test_paddle_hit();
        int n;
        n = 0;
        while (m_r == 0 && n < 400) begin
            do_tick(10'(m_y - 10), "paddle");
            n++;
        end
        checks++;
        if (m_r == 0) begin
            errors++;
            $display("FAIL paddle_timeout: got no bounce within %0d ticks, expected a bounce", n);
        end
        checks++;
        if (ball_x !== 10'd24 || ball_dir_right !== 1'b1 || miss_count !== 4'd0 || serving !== 1'b0) begin
            errors++;
            $display("FAIL paddle_bounce: got x=%0d r=%0b m=%0d s=%0b, expected x=24 r=1 m=0 s=0",
                     ball_x, ball_dir_right, miss_count, serving);
        end
    endtask

    // Keep the paddle away from the ball so every approach becomes a miss
    task automatic test_miss_saturate();
        int n;
        logic [3:0] want;
        for (int k = 1; k <= 16; k++) begin
            n = 0;
            while (m_st != 2 && n < 3000) begin
                do_tick((m_y >= 240) ? 10'd0 : 10'd400, "miss_run");
                n++;
            end
            checks++;
            if (m_st != 2) begin
                errors++;
                $display("FAIL miss_timeout: got no miss within %0d ticks, expected a miss", n);
                return;
            end
            checks++;
            if (ball_x !== 10'd0 || serving !== 1'b0) begin
                errors++;
                $display("FAIL miss_edge: got x=%0d s=%0b, expected x=0 s=0", ball_x, serving);
            end
            do_tick(10'd0, "recentre");
            want = (k > 15) ? 4'd15 : 4'(k);
            checks++;
            if (miss_count !== want || ball_x !== 10'd316 || ball_y !== 10'd236 || serving !== 1'b1 || ball_dir_right !== 1'b1) begin
                errors++;
                $display("FAIL miss_recentre: got m=%0d x=%0d y=%0d s=%0b r=%0b, expected m=%0d x=316 y=236 s=1 r=1",
                         miss_count, ball_x, ball_y, serving, ball_dir_right, want);
            end
        end
        checks++;
        if (miss_count !== 4'd15) begin
            errors++;
            $display("FAIL miss_saturate: got %0d expected 15", miss_count);
        end
    endtask

    task automatic test_reset_midplay();
        for (int i = 0; i < 65; i++) do_tick(10'd400, "pre_reset");
        @(negedge clk50M);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (ball_x !== 10'd316 || ball_y !== 10'd236 || ball_dir_right !== 1'b1 ||
            ball_dir_down !== 1'b1 || serving !== 1'b1 || miss_count !== 4'd0) begin
            errors++;
            $display("FAIL async_reset: got x=%0d y=%0d r=%0b d=%0b s=%0b m=%0d, expected x=316 y=236 r=1 d=1 s=1 m=0",
                     ball_x, ball_y, ball_dir_right, ball_dir_down, serving, miss_count);
        end
        model_reset();
        exp_q.delete();
        @(negedge clk50M);
        reset = 1'b1;
        repeat (2) @(negedge clk50M);
        for (int i = 0; i < 59; i++) do_tick(10'd400, "reserve");
        checks++;
        if (serving !== 1'b1 || ball_x !== 10'd316) begin
            errors++;
            $display("FAIL reserve_hold: got s=%0b x=%0d, expected s=1 x=316", serving, ball_x);
        end
        do_tick(10'd400, "reserve60");
        checks++;
        if (serving !== 1'b0 || ball_x !== 10'd316) begin
            errors++;
            $display("FAIL reserve_end: got s=%0b x=%0d, expected s=0 x=316", serving, ball_x);
        end
        do_tick(10'd400, "replay1");
        checks++;
        if (ball_x !== 10'd318 || ball_y !== 10'd237) begin
            errors++;
            $display("FAIL replay_move: got x=%0d y=%0d, expected x=318 y=237", ball_x, ball_y);
        end
    endtask

    initial begin
        test_reset();
        test_hold_high();
        test_serve();
        test_walls();
        test_paddle_hit();
        test_miss_saturate();
        test_reset_midplay();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
